// File: rtl/spi_master.sv
// spi_master: single-byte SPI mode-0 master with programmable chip-enable timing.
// Build option SPI_MASTER_LOOPBACK_EN feeds the receive shifter from mosi instead of miso.
module spi_master #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned CS_SETUP = 2,
   parameter int unsigned CS_HOLD  = 2,
   parameter int unsigned CS_IDLE  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] tx_data,
   output logic       busy,
   output logic       done,
   output logic [7:0] rx_data,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso,
   output logic       ce0
);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
   localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
   localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
   localparam logic [7:0] IDLE_LAST  = 8'(CS_IDLE - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] bit_q, bit_d;
   // MSB goes straight to mosi at accept, so only the remaining 7 bits are shifted.
   logic [6:0] tx_q, tx_d;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       sclk_q, sclk_d;
   logic       mosi_q, mosi_d;
   logic       ce0_q, ce0_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   logic [7:0] cnt_term;
   logic       cnt_hit;
   logic       last_bit;
   logic       rx_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
   assign rx_bit = mosi_q;
`else
   assign rx_bit = miso;
`endif

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= 8'd0;
         bit_q      <= 3'd0;
         tx_q       <= 7'd0;
         rx_shift_q <= 8'd0;
         rx_data_q  <= 8'd0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         ce0_q      <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         tx_q       <= tx_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         ce0_q      <= ce0_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // The shared divider compares against a terminal count chosen by the current state.
   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      cnt_term = 8'd0;
      case (state_q)
         SETUP:   cnt_term = SETUP_LAST;
         SHIFT:   cnt_term = DIV_LAST;
         HOLD:    cnt_term = HOLD_LAST;
         GAP:     cnt_term = IDLE_LAST;
         default: cnt_term = 8'd0;
      endcase
   end

   assign cnt_hit  = (cnt_q == cnt_term);
   assign last_bit = (bit_q == 3'd7);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SETUP;
         SETUP:   if (cnt_hit) state_d = SHIFT;
         SHIFT:   if (cnt_hit && sclk_q && last_bit) state_d = HOLD;
         HOLD:    if (cnt_hit) state_d = GAP;
         GAP:     if (cnt_hit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      tx_d       = tx_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      ce0_d      = ce0_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = 8'd0;
            bit_d = 3'd0;
            if (start) begin
               tx_d   = tx_data[6:0];
               mosi_d = tx_data[7];
               ce0_d  = 1'b0;
               busy_d = 1'b1;
            end
         end
         SETUP: begin
            cnt_d = cnt_hit ? 8'd0 : cnt_q + 8'd1;
         end
         SHIFT: begin
            cnt_d = cnt_hit ? 8'd0 : cnt_q + 8'd1;
            if (cnt_hit) begin
               if (!sclk_q) begin
                  sclk_d     = 1'b1;
                  rx_shift_d = {rx_shift_q[6:0], rx_bit};
               end else begin
                  sclk_d = 1'b0;
                  // mosi holds the last bit through HOLD; only earlier bits advance.
                  if (!last_bit) begin
                     bit_d  = bit_q + 3'd1;
                     mosi_d = tx_q[6];
                     tx_d   = {tx_q[5:0], 1'b0};
                  end
               end
            end
         end
         HOLD: begin
            cnt_d = cnt_hit ? 8'd0 : cnt_q + 8'd1;
            if (cnt_hit) begin
               ce0_d     = 1'b1;
               rx_data_d = rx_shift_q;
               done_d    = 1'b1;
            end
         end
         GAP: begin
            cnt_d  = cnt_hit ? 8'd0 : cnt_q + 8'd1;
            mosi_d = 1'b0;
            if (cnt_hit) busy_d = 1'b0;
         end
         default: begin
            cnt_d = 8'd0;
         end
      endcase
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign rx_data = rx_data_q;
   assign sclk    = sclk_q;
   assign mosi    = mosi_q;
   assign ce0     = ce0_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: random and directed bytes through spi_master against a bench slave and
// a scoreboard of expected bytes; a negedge monitor checks pin timing and results.
module tb_spi_master;

   localparam int CLK_DIV    = 2;
   localparam int CS_SETUP   = 1;
   localparam int CS_HOLD    = 1;
   localparam int CS_IDLE    = 2;
   localparam int BYTE_CYC   = CS_SETUP + 16 * CLK_DIV + CS_HOLD;
   localparam int FIRST_RISE = CS_SETUP + CLK_DIV;
   localparam int B2B_GAP    = CS_IDLE + 1;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       start   = 1'b0;
   logic       miso    = 1'b0;
   logic [7:0] tx_data = 8'd0;
   logic       busy, done, sclk, mosi, ce0;
   logic [7:0] rx_data;

   typedef struct {
      logic [7:0] tx;
      logic [7:0] rx;
      int         gap;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] slv_q[$];

   int vectors     = 0;
   int miscompares = 0;

   spi_master #(
      .CLK_DIV (CLK_DIV),
      .CS_SETUP(CS_SETUP),
      .CS_HOLD (CS_HOLD),
      .CS_IDLE (CS_IDLE)
   ) dut (
      .clk    (clk),
      .reset  (rst_n),
      .start  (start),
      .tx_data(tx_data),
      .busy   (busy),
      .done   (done),
      .rx_data(rx_data),
      .sclk   (sclk),
      .mosi   (mosi),
      .miso   (miso),
      .ce0    (ce0)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
      end
   endtask

   // What the master should have received for a byte, straight from the pin-level rules.
   function automatic logic [7:0] model_rx(input logic [7:0] tx, input logic [7:0] slave);
`ifdef SPI_MASTER_LOOPBACK_EN
      return tx;
`else
      return slave;
`endif
   endfunction

   // Slave model and monitor, sampling away from the active edge.
   int         cyc = 0, t_fall = 0, t_rise = 0, t_edge = 0, nrise = 0, nfall = 0;
   bit         in_byte = 0, busy_low = 0;
   logic       prev_ce0 = 1'b1, prev_sclk = 1'b0;
   logic [7:0] cap = 8'd0, sbyte = 8'd0;
   exp_t       e;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            in_byte = 0;
         end else begin
            if (ce0 && sclk !== prev_sclk)
               check("sclk_edge_while_ce0_high", sclk, prev_sclk);
            if (prev_ce0 && !ce0) begin
               in_byte  = 1;
               busy_low = 0;
               t_fall   = cyc;
               nrise    = 0;
               nfall    = 0;
               cap      = 8'd0;
               sbyte    = (slv_q.size() > 0) ? slv_q.pop_front() : 8'd0;
               miso     = sbyte[7];
               if (exp_q.size() > 0 && exp_q[0].gap != 0)
                  check("ce0_high_gap", cyc - t_rise, exp_q[0].gap);
            end
            if (in_byte && !ce0 && !busy) busy_low = 1;
            if (in_byte && !prev_sclk && sclk) begin
               cap = {cap[6:0], mosi};
               if (nrise == 0) check("first_rise_delay", cyc - t_fall, FIRST_RISE);
               else            check("sclk_low_cycles", cyc - t_edge, CLK_DIV);
               t_edge = cyc;
               nrise++;
            end
            if (in_byte && prev_sclk && !sclk) begin
               check("sclk_high_cycles", cyc - t_edge, CLK_DIV);
               t_edge = cyc;
               nfall++;
               if (nfall < 8) miso = sbyte[7 - nfall];
            end
            if (!prev_ce0 && ce0 && in_byte) begin
               in_byte = 0;
               t_rise  = cyc;
               check("ce0_low_cycles", cyc - t_fall, BYTE_CYC);
               check("sclk_rises", nrise, 8);
               check("sclk_falls", nfall, 8);
               check("busy_dropped_in_byte", busy_low, 0);
               check("done_with_ce0_rise", done, 1);
               check("byte_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("mosi_byte", cap, e.tx);
                  check("rx_data", rx_data, e.rx);
               end
            end else if (done) begin
               check("spurious_done", done, 0);
            end
         end
         prev_ce0  = ce0;
         prev_sclk = sclk;
      end
   end

   task automatic wait_busy(input logic val, input int budget);
      int n = 0;
      while (busy !== val && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (busy !== val) check("busy_wait_timeout", busy, val);
   endtask

   task automatic wait_rise(input int k);
      int n = 0;
      while (!(in_byte && nrise == k) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("wait_rise_reached", nrise, k);
   endtask

   task automatic send(input logic [7:0] tx, input logic [7:0] slave, input bit expect_done);
      exp_t x;
      wait_busy(1'b0, 200);
      slv_q.push_back(slave);
      if (expect_done) begin
         x.tx  = tx;
         x.rx  = model_rx(tx, slave);
         x.gap = 0;
         exp_q.push_back(x);
      end
      tx_data = tx;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      tx_data = 8'($urandom);
      wait_busy(1'b1, 4);
   endtask

   initial begin
      exp_t x;
      repeat (3) @(negedge clk);
      check("reset_ce0", ce0, 1);
      check("reset_sclk", sclk, 0);
      check("reset_mosi", mosi, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_rx_data", rx_data, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      send(8'hA5, 8'h3C, 1);
      for (int i = 0; i < 8; i++) send(8'($urandom), 8'($urandom), 1);

      // Start request while a byte is shifting must be dropped.
      send(8'h12, 8'h96, 1);
      wait_rise(2);
      tx_data = 8'hFF;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_at_collision", busy, 1);
      wait_busy(1'b0, 100);
      repeat (4) @(negedge clk);
      check("no_queued_byte", ce0, 1);

      // start held high: two bytes back to back with an echoing slave.
      slv_q.push_back(8'h01);
      slv_q.push_back(8'h80);
      x.tx = 8'h01; x.rx = model_rx(8'h01, 8'h01); x.gap = 0;
      exp_q.push_back(x);
      x.tx = 8'h80; x.rx = model_rx(8'h80, 8'h80); x.gap = B2B_GAP;
      exp_q.push_back(x);
      tx_data = 8'h01;
      start   = 1'b1;
      @(negedge clk);
      tx_data = 8'h80;
      wait_busy(1'b0, 100);
      wait_busy(1'b1, 4);
      start   = 1'b0;
      tx_data = 8'($urandom);

      // Reset in the middle of a byte aborts it with no done.
      send(8'h77, 8'h11, 0);
      wait_rise(3);
      rst_n = 1'b0;
      #1;
      check("abort_ce0", ce0, 1);
      check("abort_sclk", sclk, 0);
      check("abort_busy", busy, 0);
      check("abort_rx_data", rx_data, 0);
      check("abort_done", done, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      send(8'h5A, 8'($urandom), 1);

      // Slave drives all zeros; with loopback the byte still comes back.
      send(8'hC3, 8'h00, 1);
      for (int i = 0; i < 4; i++) send(8'($urandom), 8'($urandom), 1);

      wait_busy(1'b0, 200);
      repeat (5) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
      $fatal(1, "watchdog timeout");
   end

endmodule
